// File: rtl/usbf_crc_pkg.sv
// Shared constants, state type and strobe helper for the streaming USB CRC16 engine.
// CRC values are held in the LSB-first (reflected) form used by the SIE byte paths.
package usbf_crc_pkg;

   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;
   // x^16+x^15+x^2+1 with bit order reversed for LSB-first shifting
   localparam logic [15:0] CRC16_POLY_REF = 16'hA001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } crc_state_e;

   // True when the set bits form one run starting at bit 0 (including all-zero).
   function automatic logic strb_contig(input logic [3:0] strb);
      return ((strb & (strb + 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/usbf_crc16_step.sv
// One-byte USB CRC16 update, bit 0 of the byte shifted in first.
// Purely combinational; the stream top chains several of these per beat.
module usbf_crc16_step
   import usbf_crc_pkg::*;
(
   input  logic [15:0] crc_in_i,
   input  logic [7:0]  din_i,
   output logic [15:0] crc_out_o
);

   always_comb begin
      logic [15:0] c;
      c = crc_in_i;
      for (int b = 0; b < 8; b++) begin
         if (c[0] ^ din_i[b]) c = (c >> 1) ^ CRC16_POLY_REF;
         else                 c = c >> 1;
      end
      crc_out_o = c;
   end

endmodule

// File: rtl/usbf_crc16_stream.sv
// Streaming USB CRC16 generator/checker taking 1, 2 or 4 bytes per beat.
// Holds CRC and byte count per packet and pulses done_o one cycle after the last beat.
module usbf_crc16_stream
   import usbf_crc_pkg::*;
#(
   parameter int          DATA_W       = 8,
   parameter logic [15:0] CRC_INIT     = CRC16_INIT,
   parameter logic [15:0] CRC_RESIDUAL = CRC16_RESIDUAL,
   parameter int          LEN_W        = 11
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic                valid_i,
   input  logic [DATA_W-1:0]   data_i,
   input  logic [DATA_W/8-1:0] strb_i,
   input  logic                last_i,
   output logic                ready_o,
   output logic                done_o,
   output logic [15:0]         crc_o,
   output logic                crc_ok_o,
   output logic [LEN_W-1:0]    len_o,
   output logic                err_o
);

   localparam int NB = DATA_W / 8;

   crc_state_e       state_reg, state_next;
   logic [15:0]      crc_reg;
   logic [LEN_W-1:0] len_reg;
   logic             err_reg;

   logic [15:0]      crc_base, crc_beat;
   logic [LEN_W-1:0] len_base, len_beat;
   logic [LEN_W:0]   len_sum;
   logic [2:0]       pop;
   logic [3:0]       strb4;
   logic             accept, process, violation;

   // A start in the same cycle as a beat makes the beat the first of a fresh packet.
   assign crc_base = start_i ? CRC_INIT : crc_reg;
   assign len_base = start_i ? '0 : len_reg;

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_step
         logic [15:0] c_in, step_out, c_out;
         if (gi == 0) begin : g_first
            assign c_in = crc_base;
         end else begin : g_next
            assign c_in = g_step[gi-1].c_out;
         end
         usbf_crc16_step u_step (
            .crc_in_i  (c_in),
            .din_i     (data_i[8*gi +: 8]),
            .crc_out_o (step_out)
         );
         assign c_out = strb_i[gi] ? step_out : c_in;
      end
   endgenerate

   assign crc_beat = g_step[NB-1].c_out;

   always_comb begin
      strb4 = '0;
      strb4[NB-1:0] = strb_i;
      pop = '0;
      for (int k = 0; k < NB; k++) pop = pop + {2'b00, strb_i[k]};
   end

   assign len_sum  = {1'b0, len_base} + {{(LEN_W-2){1'b0}}, pop};
   assign len_beat = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

   // FSM outputs
   always_comb begin
      ready_o = 1'b1;
      done_o  = 1'b0;
      if (state_reg == DONE) begin
         ready_o = 1'b0;
         done_o  = 1'b1;
      end
   end

   assign accept    = valid_i & ready_o;
   assign process   = accept & (start_i | (state_reg == RUN));
   assign violation = (accept & ~start_i & (state_reg == IDLE)) |
                      (process & (~strb_contig(strb4) | (~last_i & ~(&strb_i))));

   // FSM next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_i) state_next = (valid_i & last_i) ? DONE : RUN;
         RUN:     if (valid_i & last_i) state_next = DONE;
         DONE:    state_next = start_i ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM state and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         crc_reg   <= CRC_INIT;
         len_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         err_reg   <= violation;
         if (process) begin
            crc_reg <= crc_beat;
            len_reg <= len_beat;
         end else if (start_i) begin
            crc_reg <= CRC_INIT;
            len_reg <= '0;
         end
      end
   end

   assign crc_o    = ~crc_reg;
   assign crc_ok_o = (crc_reg == CRC_RESIDUAL);
   assign len_o    = len_reg;
   assign err_o    = err_reg;

endmodule

// File: doc/usbf_crc16_stream.md
# usbf_crc16_stream

Streaming, parametrised USB CRC16 engine for generating and checking the CRC on DATA packets. It accepts 1, 2 or 4 bytes per beat, with a strobe for partial final beats. It keeps the running CRC in a register and reports the transmit CRC, a residual-check pass/fail and the payload byte count at end of packet. It sits between the SIE tx/rx byte paths and the endpoint buffers, so the SIE no longer steps the CRC one byte at a time.

## Interface
- DATA_W, 8, beat width in bits; legal values 8, 16, 32; NB = DATA_W/8 bytes per beat
- CRC_INIT, 16'hFFFF, CRC register value loaded on start
- CRC_RESIDUAL, 16'hB001, register value that indicates a good packet (data plus received CRC)
- LEN_W, 11, width of the byte counter
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  begin new packet: load CRC_INIT, clear counter
- valid_i  in  1  beat present
- data_i  in  DATA_W  beat data; byte k = data_i[8k+7:8k]; byte 0 is processed first
- strb_i  in  NB  byte enables; contiguous from bit 0
- last_i  in  1  final beat of packet
- ready_o  out  1  beat accepted when valid_i & ready_o
- done_o  out  1  one-cycle pulse: results valid
- crc_o  out  16  ~crc register; sent low byte first
- crc_ok_o  out  1  crc register == CRC_RESIDUAL
- len_o  out  LEN_W  bytes accepted this packet
- err_o  out  1  one-cycle pulse on protocol violation

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready_o=1. start_i moves to RUN. A beat with valid_i and without start_i is dropped and pulses err_o.
- RUN: ready_o=1. Each accepted beat updates the CRC register through the enabled bytes in order (byte 0 first). len += popcount(strb_i). An accepted beat with last_i moves to DONE.
- DONE: lasts one cycle. ready_o=0, done_o=1, then returns to IDLE.
- crc_o, crc_ok_o and len_o are combinational from the registers. They hold their values until the next start_i.
- start_i with valid_i in the same cycle: the beat is processed against CRC_INIT, and len starts from that beat.
- start_i in RUN: aborts the current packet (no done_o) and restarts as above.
- start_i in DONE: done_o still pulses. The next state is RUN and the registers reload.
- strb_i=0 on the last beat is legal (ZLP or trailing empty beat): CRC unchanged, the state still moves to DONE.
- A non-contiguous strb_i, or a partial strb_i on a non-last beat: err_o pulses and the beat is still processed using its enabled bytes.
- len saturates at all-ones and does not wrap.
- Generate use: feed the payload only, then transmit crc_o[7:0] followed by crc_o[15:8].
- Check use: feed the payload plus the 2 received CRC bytes, then test crc_ok_o.

## Timing
- Reset (asynchronous, rst_ni=0): state=IDLE, crc register=CRC_INIT, len=0, done_o=0, err_o=0, ready_o=1. As a consequence, crc_o=16'h0000 and crc_ok_o=0.
- Reset in the middle of a packet discards the packet; no done_o is produced.
- Latency: the last beat is accepted in cycle N. done_o is high and the results are valid in cycle N+1. A new start_i is accepted in cycle N+1.
- Throughput: one beat per cycle within a packet. There is one dead cycle (DONE) between packets.
- All NB byte steps are chained combinationally within one cycle; there is no internal pipelining.

## Structure
- Package usbf_crc_pkg contains:
  - CRC16_INIT (16'hFFFF) and CRC16_RESIDUAL (16'hB001)
  - the state enum {IDLE, RUN, DONE}
  - a function returning whether a strobe is contiguous
- Sub-module usbf_crc16_step: purely combinational one-byte update (crc_in_i[15:0], din_i[7:0] -> crc_out_o[15:0]) using the USB polynomial x^16+x^15+x^2+1, in the codebase's bit ordering.
  - It is instantiated NB times in a chain.
  - A disabled byte passes its input through unchanged.

## Test plan
- ZLP, DATA_W=8: start_i together with valid_i, strb=0, last=1 -> done_o one cycle later, crc_o=16'h0000, len_o=0, crc_ok_o=0.
- Bytes 00 01 02 03 at DATA_W=8, 16 and 32 (32: one beat, strb=4'hF) -> all three produce identical crc_o, and it matches the bit-serial golden model; len_o=4.
- Loopback check: the payload from the previous case followed by crc_o[7:0], crc_o[15:8] -> crc_ok_o=1. Flip any single data bit -> crc_ok_o=0.
- DATA_W=32, 5-byte packet: second beat has strb=4'b0001, last=1 -> crc_o equals the DATA_W=8 result for the same 5 bytes; len_o=5. Repeat with strb=4'b0101 -> err_o pulses.
- Abort and reset: start, 2 beats, start again, 1 beat 0xA5 last -> result equals a fresh single-byte 0xA5 packet, with exactly one done_o. Assert rst_ni mid-packet -> outputs return to their reset values immediately.
- Back-to-back packets: start_i asserted in the DONE cycle -> done_o still pulses, ready_o=0 for that cycle, and the second packet's results are independent of the first.
